fetch_decode_execute: RTL and testbench

Combined fetch/decode/execute front end of the multi-cycle RV32I core. On a start request it fetches one 32-bit instruction byte-serially over the shared 8-bit memory bus, decodes it, reads two source registers from the external register file, and produces the ALU result, memory address and PC-relative jump offset for the core's sequencer, which owns the PC, memory-access stage and register write-back.

---
 rtl/fetch_decode_execute_if.sv | 34 +++
 rtl/fetch_decode_execute.sv | 231 +++++++++++++++++++++++
 tb/tb_fetch_decode_execute.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_decode_execute_if.sv
// Start handshake, byte-wide memory bus, register-file read ports and result bus
// between the core sequencer (master) and the fetch/decode/execute front end (slave).
interface fetch_decode_execute_if;
    logic        start_i;
    logic [31:0] pc_i;
    logic        busy_o;
    logic [7:0]  memd_i;
    logic [31:0] mema_o;
    logic [4:0]  reg1a_o;
    logic [4:0]  reg2a_o;
    logic [31:0] reg1d_i;
    logic [31:0] reg2d_i;
    logic        done_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic [4:0]  op_o;
    logic [2:0]  sel_o;
    logic [4:0]  regd_o;
    logic [31:0] res_o;
    logic [31:0] addr_o;
    logic [31:0] jump_o;

    modport slave (
        input  start_i, pc_i, memd_i, reg1d_i, reg2d_i,
        output busy_o, mema_o, reg1a_o, reg2a_o, done_o, pc_o, inst_o, op_o, sel_o,
               regd_o, res_o, addr_o, jump_o
    );

    modport master (
        output start_i, pc_i, memd_i, reg1d_i, reg2d_i,
        input  busy_o, mema_o, reg1a_o, reg2a_o, done_o, pc_o, inst_o, op_o, sel_o,
               regd_o, res_o, addr_o, jump_o
    );
endinterface

// File: rtl/fetch_decode_execute.sv
// Multi-cycle RV32I front end: byte-serial fetch, decode, register read and execute of one
// instruction per start request; results are held until the next instruction executes.
module fetch_decode_execute (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    fetch_decode_execute_if.slave  bus_io
);
    localparam logic [4:0] OpLoad = 5'b00000, OpImm = 5'b00100, OpAuipc = 5'b00101;
    localparam logic [4:0] OpStore = 5'b01000, OpReg = 5'b01100, OpLui = 5'b01101;
    localparam logic [4:0] OpBranch = 5'b11000, OpJalr = 5'b11001, OpJal = 5'b11011;

    typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExec, StDone} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] fpc_q, fpc_d, ibuf_q, ibuf_d, dimm_q, dimm_d;
    logic [4:0]  dop_q, dop_d, dregd_q, dregd_d, dr1_q, dr1_d, dr2_q, dr2_d;
    logic [2:0]  dsel_q, dsel_d;
    logic        dalt_q, dalt_d;
    logic [31:0] pco_q, pco_d, insto_q, insto_d, reso_q, reso_d;
    logic [31:0] addro_q, addro_d, jumpo_q, jumpo_d;
    logic [4:0]  opo_q, opo_d, regdo_q, regdo_d;
    logic [2:0]  selo_q, selo_d;
    logic [4:0]  dec_op;
    logic [31:0] rs1, rs2, jalr_tgt;

    assign rs1 = bus_io.reg1d_i;
    assign rs2 = bus_io.reg2d_i;

    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] f, input logic alt);
        logic [31:0] r;
        logic [31:0] sra;
        sra = $signed(a) >>> b[4:0];
        unique case (f)
            3'b000:  r = alt ? a - b : a + b;
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'd0, $signed(a) < $signed(b)};
            3'b011:  r = {31'd0, a < b};
            3'b100:  r = a ^ b;
            3'b101:  r = alt ? sra : a >> b[4:0];
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    function automatic logic taken(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] f);
        case (f)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fpc_d    = fpc_q;
        ibuf_d   = ibuf_q;
        dimm_d   = dimm_q;
        dop_d    = dop_q;
        dregd_d  = dregd_q;
        dr1_d    = dr1_q;
        dr2_d    = dr2_q;
        dsel_d   = dsel_q;
        dalt_d   = dalt_q;
        pco_d    = pco_q;
        insto_d  = insto_q;
        reso_d   = reso_q;
        addro_d  = addro_q;
        jumpo_d  = jumpo_q;
        opo_d    = opo_q;
        regdo_d  = regdo_q;
        selo_d   = selo_q;
        dec_op   = ibuf_q[6:2];
        jalr_tgt = (rs1 + dimm_q) & ~32'd1;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus_io.start_i) begin
                    state_d = StFetch;
                    cnt_d   = 3'd0;
                    fpc_d   = bus_io.pc_i;
                end
            end
            StFetch: begin
                // memd_i lags its address by one cycle, so byte n lands when cnt_q = n+1
                case (cnt_q)
                    3'd1:    ibuf_d[7:0]   = bus_io.memd_i;
                    3'd2:    ibuf_d[15:8]  = bus_io.memd_i;
                    3'd3:    ibuf_d[23:16] = bus_io.memd_i;
                    3'd4:    ibuf_d[31:24] = bus_io.memd_i;
                    default: ;
                endcase
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd4) state_d = StDecode;
            end
            StDecode: begin
                dop_d  = dec_op;
                dsel_d = ibuf_q[14:12];
                dalt_d = ibuf_q[30];
                case (dec_op)
                    OpLui, OpAuipc: dimm_d = {ibuf_q[31:12], 12'd0};
                    OpJal:    dimm_d = {{12{ibuf_q[31]}}, ibuf_q[19:12], ibuf_q[20],
                                        ibuf_q[30:21], 1'b0};
                    OpBranch: dimm_d = {{20{ibuf_q[31]}}, ibuf_q[7], ibuf_q[30:25],
                                        ibuf_q[11:8], 1'b0};
                    OpStore:  dimm_d = {{20{ibuf_q[31]}}, ibuf_q[31:25], ibuf_q[11:7]};
                    default:  dimm_d = {{20{ibuf_q[31]}}, ibuf_q[31:20]};
                endcase
                case (dec_op)
                    OpLui, OpAuipc, OpJal, OpJalr, OpLoad, OpImm, OpReg: dregd_d = ibuf_q[11:7];
                    default: dregd_d = 5'd0;
                endcase
                case (dec_op)
                    OpJalr, OpBranch, OpLoad, OpStore, OpImm, OpReg: dr1_d = ibuf_q[19:15];
                    default: dr1_d = 5'd0;
                endcase
                case (dec_op)
                    OpBranch, OpStore, OpReg: dr2_d = ibuf_q[24:20];
                    default: dr2_d = 5'd0;
                endcase
                state_d = StExec;
            end
            StExec: begin
                pco_d   = fpc_q;
                insto_d = ibuf_q;
                opo_d   = dop_q;
                selo_d  = dsel_q;
                regdo_d = dregd_q;
                reso_d  = 32'd0;
                addro_d = 32'd0;
                jumpo_d = 32'd4;
                case (dop_q)
                    OpLui:   reso_d = dimm_q;
                    OpAuipc: reso_d = fpc_q + dimm_q;
                    OpJal: begin
                        reso_d  = fpc_q + 32'd4;
                        jumpo_d = dimm_q;
                    end
                    OpJalr: begin
                        reso_d  = fpc_q + 32'd4;
                        jumpo_d = jalr_tgt - fpc_q;
                    end
                    OpBranch: begin
                        if (taken(rs1, rs2, dsel_q)) begin
                            reso_d  = 32'd1;
                            jumpo_d = dimm_q;
                        end
                    end
                    OpLoad:  addro_d = rs1 + dimm_q;
                    OpStore: begin
                        addro_d = rs1 + dimm_q;
                        reso_d  = rs2;
                    end
                    // inst[30] only selects SRAI among the immediate forms
                    OpImm:   reso_d = alu(rs1, dimm_q, dsel_q, dalt_q && (dsel_q == 3'b101));
                    OpReg:   reso_d = alu(rs1, rs2, dsel_q, dalt_q);
                    default: ;
                endcase
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            fpc_q   <= 32'd0;
            ibuf_q  <= 32'd0;
            dimm_q  <= 32'd0;
            dop_q   <= 5'd0;
            dregd_q <= 5'd0;
            dr1_q   <= 5'd0;
            dr2_q   <= 5'd0;
            dsel_q  <= 3'd0;
            dalt_q  <= 1'b0;
            pco_q   <= 32'd0;
            insto_q <= 32'd0;
            reso_q  <= 32'd0;
            addro_q <= 32'd0;
            jumpo_q <= 32'd0;
            opo_q   <= 5'd0;
            regdo_q <= 5'd0;
            selo_q  <= 3'd0;
        end else if (rdy) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fpc_q   <= fpc_d;
            ibuf_q  <= ibuf_d;
            dimm_q  <= dimm_d;
            dop_q   <= dop_d;
            dregd_q <= dregd_d;
            dr1_q   <= dr1_d;
            dr2_q   <= dr2_d;
            dsel_q  <= dsel_d;
            dalt_q  <= dalt_d;
            pco_q   <= pco_d;
            insto_q <= insto_d;
            reso_q  <= reso_d;
            addro_q <= addro_d;
            jumpo_q <= jumpo_d;
            opo_q   <= opo_d;
            regdo_q <= regdo_d;
            selo_q  <= selo_d;
        end
    end

    assign bus_io.busy_o  = (state_q == StFetch) || (state_q == StDecode) || (state_q == StExec);
    assign bus_io.done_o  = (state_q == StDone);
    assign bus_io.mema_o  = (state_q == StFetch && cnt_q < 3'd4) ? fpc_q + {29'd0, cnt_q} : 32'd0;
    assign bus_io.reg1a_o = dr1_q;
    assign bus_io.reg2a_o = dr2_q;
    assign bus_io.pc_o    = pco_q;
    assign bus_io.inst_o  = insto_q;
    assign bus_io.op_o    = opo_q;
    assign bus_io.sel_o   = selo_q;
    assign bus_io.regd_o  = regdo_q;
    assign bus_io.res_o   = reso_q;
    assign bus_io.addr_o  = addro_q;
    assign bus_io.jump_o  = jumpo_q;
endmodule

// File: tb/tb_fetch_decode_execute.sv
// Directed bench for fetch_decode_execute: a table of instructions with hand-computed results,
// plus sequences for start-while-busy, rdy stalls and reset mid-fetch.
module tb_fetch_decode_execute;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] res;
        logic [31:0] addr;
        logic [31:0] jump;
        logic [4:0]  regd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [7:0]  mem [1024];
    logic [31:0] rf [32];
    vec_t vecs [14];

    fetch_decode_execute_if bus_if ();

    fetch_decode_execute dut (
        .clk    (clk),
        .rst    (rst),
        .rdy    (rdy),
        .bus_io (bus_if)
    );

    always #5 clk = ~clk;

    // memory answers one cycle after its address and stalls with the core
    always @(posedge clk) if (rdy) bus_if.memd_i <= mem[bus_if.mema_o[9:0]];
    assign bus_if.reg1d_i = rf[bus_if.reg1a_o];
    assign bus_if.reg2d_i = rf[bus_if.reg2a_o];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        logic [4:0] a1, a2;
        for (int k = 0; k < 4; k++) mem[(v.pc[9:0] + 10'(k))] = v.inst[8*k +: 8];
        a1 = v.inst[19:15];
        a2 = v.inst[24:20];
        if (a1 != 5'd0) rf[a1] = v.r1;
        if (a2 != 5'd0) rf[a2] = v.r2;
    endtask

    // returns #1 into C1
    task automatic start_instr(input logic [31:0] pc);
        @(negedge clk);
        bus_if.start_i = 1'b1;
        bus_if.pc_i    = pc;
        @(posedge clk);
        #1;
        bus_if.start_i = 1'b0;
    endtask

    task automatic wait_done(input logic [31:0] pc, input int c0, input bit chk_m,
                             input int exp_lat);
        int cyc;
        cyc = c0;
        forever begin
            if (chk_m) begin
                chk("mema", bus_if.mema_o,
                    (cyc >= 1 && cyc <= 4) ? pc + 32'(cyc - 1) : 32'd0);
                if (cyc < exp_lat) chk("busy", {31'd0, bus_if.busy_o}, 32'd1);
            end
            if (bus_if.done_o === 1'b1 || cyc >= 40) break;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("busy_at_done", {31'd0, bus_if.busy_o}, 32'd0);
    endtask

    task automatic check_outs(input vec_t v, input int idx);
        chk($sformatf("v%0d res", idx), bus_if.res_o, v.res);
        chk($sformatf("v%0d addr", idx), bus_if.addr_o, v.addr);
        chk($sformatf("v%0d jump", idx), bus_if.jump_o, v.jump);
        chk($sformatf("v%0d regd", idx), {27'd0, bus_if.regd_o}, {27'd0, v.regd});
        chk($sformatf("v%0d pc", idx), bus_if.pc_o, v.pc);
        chk($sformatf("v%0d inst", idx), bus_if.inst_o, v.inst);
        chk($sformatf("v%0d op", idx), {27'd0, bus_if.op_o}, {27'd0, v.inst[6:2]});
        chk($sformatf("v%0d sel", idx), {29'd0, bus_if.sel_o}, {29'd0, v.inst[14:12]});
    endtask

    task automatic run_one(input vec_t v, input int idx);
        load(v);
        start_instr(v.pc);
        wait_done(v.pc, 1, 1'b1, 8);
        check_outs(v, idx);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, " busy"}, {31'd0, bus_if.busy_o}, 32'd0);
        chk({nm, " done"}, {31'd0, bus_if.done_o}, 32'd0);
        chk({nm, " mema"}, bus_if.mema_o, 32'd0);
        chk({nm, " res"}, bus_if.res_o, 32'd0);
        chk({nm, " jump"}, bus_if.jump_o, 32'd0);
        chk({nm, " addr"}, bus_if.addr_o, 32'd0);
        chk({nm, " pc"}, bus_if.pc_o, 32'd0);
        chk({nm, " inst"}, bus_if.inst_o, 32'd0);
        chk({nm, " regd"}, {27'd0, bus_if.regd_o}, 32'd0);
        chk({nm, " reg1a"}, {27'd0, bus_if.reg1a_o}, 32'd0);
    endtask

    initial begin
        bus_if.start_i = 1'b0;
        bus_if.pc_i    = 32'd0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        //         pc          inst          r1            r2            res           addr        jump          rd
        vecs[0]  = '{32'h100, 32'h00500093, 32'h0,        32'h0,        32'h5,        32'h0,      32'h4,        5'd1};
        vecs[1]  = '{32'h200, 32'h402081B3, 32'h5,        32'h7,        32'hFFFFFFFE, 32'h0,      32'h4,        5'd3};
        vecs[2]  = '{32'h204, 32'h4040D093, 32'h80000000, 32'h0,        32'hF8000000, 32'h0,      32'h4,        5'd1};
        vecs[3]  = '{32'h208, 32'h00208863, 32'h55,       32'h55,       32'h1,        32'h0,      32'h10,       5'd0};
        vecs[4]  = '{32'h208, 32'h00208863, 32'h55,       32'h56,       32'h0,        32'h0,      32'h4,        5'd0};
        vecs[5]  = '{32'h20,  32'hFF9FF0EF, 32'h0,        32'h0,        32'h24,       32'h0,      32'hFFFFFFF8, 5'd1};
        vecs[6]  = '{32'h10,  32'h00328067, 32'h40,       32'h0,        32'h14,       32'h0,      32'h32,       5'd0};
        vecs[7]  = '{32'h180, 32'h0020A423, 32'h1000,     32'hAB,       32'hAB,       32'h1008,   32'h4,        5'd0};
        vecs[8]  = '{32'h184, 32'hFFC0A283, 32'h1000,     32'h0,        32'h0,        32'hFFC,    32'h4,        5'd5};
        vecs[9]  = '{32'h0,   32'h123453B7, 32'h0,        32'h0,        32'h12345000, 32'h0,      32'h4,        5'd7};
        vecs[10] = '{32'h300, 32'h00001117, 32'h0,        32'h0,        32'h1300,     32'h0,      32'h4,        5'd2};
        vecs[11] = '{32'h310, 32'h00000073, 32'h0,        32'h0,        32'h0,        32'h0,      32'h4,        5'd0};
        vecs[12] = '{32'h320, 32'h0020B233, 32'h1,        32'hFFFFFFFF, 32'h1,        32'h0,      32'h4,        5'd4};
        vecs[13] = '{32'h330, 32'h0020C863, 32'hFFFFFFFF, 32'h1,        32'h1,        32'h0,      32'h10,       5'd0};

        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // back-to-back: each start is issued in the previous instruction's done cycle
        for (int i = 0; i < 14; i++) run_one(vecs[i], i);

        @(posedge clk);
        #1;
        chk("done_single_cycle", {31'd0, bus_if.done_o}, 32'd0);
        chk("held_res", bus_if.res_o, vecs[13].res);

        // start while busy is ignored
        load(vecs[0]);
        start_instr(vecs[0].pc);
        @(posedge clk);
        #1;
        bus_if.start_i = 1'b1;
        bus_if.pc_i    = 32'h200;
        @(posedge clk);
        #1;
        bus_if.start_i = 1'b0;
        wait_done(vecs[0].pc, 3, 1'b1, 8);
        chk("busy_start res", bus_if.res_o, 32'h5);
        chk("busy_start pc", bus_if.pc_o, 32'h100);

        // rdy low for three cycles in C3 stretches latency to 11
        load(vecs[1]);
        start_instr(vecs[1].pc);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rdy = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("stall mema", bus_if.mema_o, 32'h202);
        end
        rdy = 1'b1;
        wait_done(vecs[1].pc, 6, 1'b0, 11);
        check_outs(vecs[1], 100);

        // reset in C4 discards the instruction and clears every output
        load(vecs[5]);
        start_instr(vecs[5].pc);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("c4 mema", bus_if.mema_o, 32'h23);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero("midrst");
        chk("midrst op", {27'd0, bus_if.op_o}, 32'd0);
        rst = 1'b0;
        run_one(vecs[7], 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
